// File: rtl/mem_access_ctrl.sv
// Load/store initiator between the MEM stage and a big-endian byte-lane RAM.
// One request in flight: IDLE -> ACCESS -> RESP, or IDLE -> RESP on alignment error.
module mem_access_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_sel,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_we;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [1:0]        r_off;
  logic              r_err;
  logic [31:0]       r_rdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;

  logic        w_accept;
  logic        w_req_err;
  logic [31:0] w_wrep;
  logic [3:0]  w_sel;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  assign w_accept = (r_state == S_IDLE) && req_valid;

  always_comb begin
    w_req_err = 1'b0;
    unique case (req_size)
      2'b00:   w_req_err = 1'b0;
      2'b01:   w_req_err = req_addr[0];
      2'b10:   w_req_err = |req_addr[1:0];
      default: w_req_err = 1'b1;
    endcase
  end

  always_comb begin
    w_wrep = req_wdata;
    unique case (req_size)
      2'b00:   w_wrep = {4{req_wdata[7:0]}};
      2'b01:   w_wrep = {2{req_wdata[15:0]}};
      default: w_wrep = req_wdata;
    endcase
  end

  // Offset k addresses lane 3-k, i.e. bits [31-8k -: 8].
  assign w_byte = 8'(mem_rdata >> {~r_off, 3'b000});
  assign w_half = r_off[1] ? mem_rdata[15:0] : mem_rdata[31:16];

  always_comb begin
    w_load = mem_rdata;
    unique case (r_size)
      2'b00:   w_load = {{24{~r_uns & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{~r_uns & w_half[15]}}, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  always_comb begin
    w_sel = 4'b1111;
    unique case (r_size)
      2'b00:   w_sel = 4'b1000 >> r_off;
      2'b01:   w_sel = r_off[1] ? 4'b0011 : 4'b1100;
      default: w_sel = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (req_valid) w_next = w_req_err ? S_RESP : S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   if (resp_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (r_state == S_IDLE);
    resp_valid = (r_state == S_RESP);
    mem_ce     = (r_state == S_ACCESS);
    mem_we     = (r_state == S_ACCESS) && r_we;
    mem_sel    = (r_state == S_ACCESS) ? w_sel : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we        <= 1'b0;
      r_size      <= 2'b00;
      r_uns       <= 1'b0;
      r_off       <= 2'b00;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      if (w_accept) begin
        r_we    <= req_we;
        r_size  <= req_size;
        r_uns   <= req_unsigned;
        r_off   <= req_addr[1:0];
        r_err   <= w_req_err;
        r_rdata <= '0;
        // Errored requests never touch the RAM, so its lanes keep their last value.
        if (!w_req_err) begin
          r_mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
          r_mem_wdata <= w_wrep;
        end
      end
      if (r_state == S_ACCESS) r_rdata <= r_we ? '0 : w_load;
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store initiator sitting between the MEM pipeline stage and the byte-lane data RAM. Accepts one load or store request at a time over a valid/ready handshake, checks alignment, drives the RAM's ce/we/addr/sel/data lanes for one access cycle, and returns sign- or zero-extended load data (or a store acknowledge) over a valid/ready response channel. Byte ordering is big-endian: byte offset 0 is lane 3, bits [31:24].

## Interface
- ADDR_W, 32, width of request and RAM address.
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal-size request.
- mem_ce  out  1  RAM chip enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0).
- mem_sel  out  4  byte-lane select.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  RAM combinational read data.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid: latch we/size/unsigned/addr/wdata. If error -> RESP with resp_err=1, no RAM access. Else -> ACCESS.
- Error: size 11; half with addr[0]=1; word with addr[1:0]!=0.
- ACCESS (exactly one cycle): mem_ce=1, mem_we=req_we latched, mem_addr={addr[ADDR_W-1:2],2'b00}, mem_sel/mem_wdata per below. Store commits at the rising edge ending ACCESS. Load: mem_rdata captured at that same edge. -> RESP.
- RESP: resp_valid=1, resp_rdata/resp_err held stable until resp_ready=1; on that edge -> IDLE.
- mem_sel: byte offset k -> 4'b1000>>k; half offset 0 -> 1100, offset 2 -> 0011; word -> 1111.
- mem_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- Load extract: byte offset k -> rdata[31-8k -: 8]; half offset 0 -> [31:16], offset 2 -> [15:0]; extend to 32 bits per req_unsigned; word unchanged.
- Outside ACCESS: mem_ce=0, mem_we=0, mem_sel=0; mem_addr/mem_wdata hold last value.

## Timing
- Reset values: state IDLE, req_ready=1 after reset, resp_valid=0, resp_rdata=0, resp_err=0, mem_ce=0, mem_we=0, mem_sel=0, mem_addr=0, mem_wdata=0.
- All outputs are registered or decoded purely from registered state; no combinational path req_* -> mem_* or resp_ready -> req_ready.
- Normal access: request accepted at edge N; ACCESS in cycle N..N+1; resp_valid high from edge N+1 (after ACCESS edge, i.e. second cycle after acceptance); minimum turnaround 3 cycles per request with resp_ready held high.
- Error access: resp_valid high the cycle after acceptance (2-cycle turnaround).
- resp_ready low: RESP held indefinitely, req_ready stays 0, no RAM activity.
- req_valid while not IDLE: ignored, not latched.
- rst high in any state: next state IDLE, all outputs to reset values at that edge; a store in ACCESS coincident with rst still reaches the RAM (RAM has no reset), its response is discarded.

## Test plan
- Store word 0xDEADBEEF to 0x10, then load word 0x10 -> ACCESS shows mem_sel=1111, mem_addr=0x10; load resp_rdata=0xDEADBEEF, resp_err=0, resp_valid 2 cycles after accept.
- Store byte 0xA5 to 0x21 (word at 0x20 preset 0x11223344) -> mem_sel=0100, mem_wdata=0xA5A5A5A5; load word 0x20 returns 0x11A53344; LB 0x21 returns 0xFFFFFFA5, LBU returns 0x000000A5.
- Store half 0x8001 to 0x32 -> mem_sel=0011; LH 0x32 returns 0xFFFF8001, LHU returns 0x00008001.
- LW 0x42, LH 0x43, size 11 -> resp_err=1, resp_rdata=0, mem_ce never asserted, resp 1 cycle after accept.
- Hold resp_ready=0 for 5 cycles with req_valid high -> resp_valid/resp_rdata stable, req_ready=0, second request accepted only after response handshake.
- Assert rst during ACCESS and during RESP -> next cycle IDLE, resp_valid=0, mem_ce=0, req_ready=1.
